// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and default timing for button_conditioner
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 2500;
  localparam int DEF_REPEAT_DELAY = 2500000;
  localparam int DEF_REPEAT_PERIOD = 1000000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with async active-high reset
//   clk - clock, rst - async reset, d - async input, q - synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= 1'b0;
      q <= 1'b0;
    end else begin
      meta_q <= d;
      q <= meta_q;
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounce a push-button into step pulses with optional auto-repeat
//   clk_out     - clock
//   reset_use   - async active-high reset
//   btn_raw     - raw bouncing button level
//   step_pulse  - one-cycle pulse per accepted press (or repeat)
//   btn_stable  - debounced level
//   press_count - step_pulse count modulo 16
// Define BTN_AUTOREPEAT_EN to build in auto-repeat while the button is held.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic       clk_out,
  input  logic       reset_use,
  input  logic       btn_raw,
  output logic       step_pulse,
  output logic       btn_stable,
  output logic [3:0] press_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_conditioner: illegal timing parameters");
  end
  btn_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic step_pulse_q, btn_stable_q, pulse;
  logic [3:0] press_count_q, press_count_d;
  logic btn_s;
  logic rpt_fire;
  sync_2ff u_sync (.clk(clk_out), .rst(reset_use), .d(btn_raw), .q(btn_s));
`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = RPT_MAX > 1 ? $clog2(RPT_MAX) : 1;
  logic [RW-1:0] rpt_q, rpt_d;
  // A repeat is suppressed for one cycle if it would sit right behind another pulse.
  assign rpt_fire = rpt_q == '0 && !step_pulse_q;
  // Counts only while HELD with the button seen high; frozen across RELEASE_WAIT so a
  // release bounce resumes the schedule, reloaded once the press is fully over.
  always_comb
    rpt_d = state_q == HELD ? (btn_s ? (rpt_q == '0 ? (rpt_fire ? RW'(REPEAT_PERIOD - 1) : rpt_q) : rpt_q - 1'b1) : rpt_q)
          : state_q == RELEASE_WAIT ? rpt_q : RW'(REPEAT_DELAY - 1);
  always_ff @(posedge clk_out or posedge reset_use)
    if (reset_use) rpt_q <= RW'(REPEAT_DELAY - 1);
    else rpt_q <= rpt_d;
`else
  assign rpt_fire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pulse = 1'b0;
    case (state_q)
      IDLE:
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d = CW'(DEBOUNCE_CYCLES - 1);
        end
      PRESS_WAIT:
        if (!btn_s) state_d = IDLE;
        else if (cnt_q == '0) begin
          state_d = HELD;
          pulse = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      HELD:
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d = CW'(DEBOUNCE_CYCLES - 1);
        end else pulse = rpt_fire;
      RELEASE_WAIT:
        if (btn_s) state_d = HELD;
        else if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    press_count_d = press_count_q + {3'b000, pulse};
  end
  always_ff @(posedge clk_out or posedge reset_use)
    if (reset_use) begin
      state_q <= IDLE;
      cnt_q <= '0;
      step_pulse_q <= 1'b0;
      btn_stable_q <= 1'b0;
      press_count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      step_pulse_q <= pulse;
      btn_stable_q <= state_d == HELD || state_d == RELEASE_WAIT;
      press_count_q <= press_count_d;
    end
  assign step_pulse = step_pulse_q;
  assign btn_stable = btn_stable_q;
  assign press_count = press_count_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: self-checking bench for button_conditioner
module tb_button_conditioner;
  localparam int D = 4, RD = 8, RP = 4;
  logic clk_out = 1'b0, reset_use = 1'b1, btn_raw = 1'b0;
  logic step_pulse, btn_stable;
  logic [3:0] press_count;
  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk_out(clk_out), .reset_use(reset_use), .btn_raw(btn_raw),
    .step_pulse(step_pulse), .btn_stable(btn_stable), .press_count(press_count)
  );
  always #5 clk_out = ~clk_out;
  int vectors = 0, miscompares = 0, cyc = 0;
  // Reference model: raw delay line, run length of input disagreeing with the stable level,
  // and the number of held cycles since the press was accepted.
  logic d1, d2, m_stable, m_pulse, prev_pulse;
  int run, n;
  logic [3:0] m_count;
  int pulses[$];
  typedef struct {logic raw; logic pulse; logic stable; logic [3:0] count;} vec_t;
  vec_t tbl[20];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic model_reset;
    d1 = 0; d2 = 0; m_stable = 0; m_pulse = 0; run = 0; n = 0; m_count = 0; prev_pulse = 0;
  endtask
  task automatic model_edge(input logic raw);
    logic seen;
    seen = d2;
    d2 = d1;
    d1 = raw;
    m_pulse = 0;
    if (seen != m_stable) begin
      run++;
      if (run == D + 1) begin
        m_stable = seen;
        run = 0;
        if (seen) begin
          m_pulse = 1;
          n = 0;
        end
      end
    end else begin
      if (m_stable && run == 0) begin
        n++;
`ifdef BTN_AUTOREPEAT_EN
        if (n >= RD && (n - RD) % RP == 0) m_pulse = 1;
`endif
      end
      run = 0;
    end
    m_count = m_count + {3'b000, m_pulse};
  endtask
  task automatic step(input logic raw);
    btn_raw = raw;
    @(posedge clk_out);
    model_edge(raw);
    cyc++;
    @(negedge clk_out);
    check("step_pulse", step_pulse, m_pulse);
    check("btn_stable", btn_stable, m_stable);
    check("press_count", press_count, m_count);
    check("no_back_to_back", step_pulse && prev_pulse, 0);
    prev_pulse = step_pulse;
    if (step_pulse) pulses.push_back(cyc);
  endtask
  task automatic apply_reset;
    reset_use = 1'b1;
    #1;
    check("rst_step_pulse", step_pulse, 0);
    check("rst_btn_stable", btn_stable, 0);
    check("rst_press_count", press_count, 0);
    model_reset();
    @(negedge clk_out);
    reset_use = 1'b0;
  endtask
  initial begin
    int base;
    for (int i = 0; i < 20; i++) begin
      tbl[i].raw = i >= 2 && i < 12;
      tbl[i].pulse = i == 8;
      tbl[i].stable = i >= 8 && i <= 17;
      tbl[i].count = i >= 8 ? 4'd1 : 4'd0;
    end
    model_reset();
    @(negedge clk_out);
    apply_reset();
    // clean press and release against hand-derived expectations
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].raw);
      check("tbl_pulse", step_pulse, tbl[i].pulse);
      check("tbl_stable", btn_stable, tbl[i].stable);
      check("tbl_count", press_count, tbl[i].count);
    end
    // bounce on press: one pulse, 6 edges after the last rise
    pulses.delete();
    base = cyc;
    for (int j = 0; j < 26; j++) step(j < 3 || (j >= 4 && j < 16));
    check("bounce_pulses", pulses.size(), 1);
    if (pulses.size() > 0) check("bounce_delay", pulses[0] - base - 1, 10);
    // release bounce while held
    pulses.delete();
    for (int j = 0; j < 24; j++) begin
      step(!(j == 12 || j == 13));
      if (j >= 6) check("relbounce_stable", btn_stable, 1);
    end
`ifdef BTN_AUTOREPEAT_EN
    check("relbounce_pulses", pulses.size(), 3);
`else
    check("relbounce_pulses", pulses.size(), 1);
`endif
    repeat (12) step(0);
    // press_count wrap
    apply_reset();
    pulses.delete();
    for (int k = 0; k < 17; k++) begin
      repeat (8) step(1);
      repeat (8) step(0);
    end
    check("wrap_pulses", pulses.size(), 17);
    check("wrap_count", press_count, 1);
    // reset in the middle of PRESS_WAIT with the button held through deassert
    repeat (3) step(1);
    pulses.delete();
    apply_reset();
    base = cyc;
    repeat (12) step(1);
    check("rstmid_pulses", pulses.size(), 1);
    if (pulses.size() > 0) check("rstmid_delay", pulses[0] - base - 1, 6);
    repeat (10) step(0);
    // long hold
    pulses.delete();
    base = cyc;
    repeat (37) step(1);
    if (pulses.size() > 0) check("hold_first", pulses[0] - base - 1, 6);
`ifdef BTN_AUTOREPEAT_EN
    check("hold_pulses", pulses.size(), 7);
    for (int k = 1; k < pulses.size(); k++) check("hold_gap", pulses[k] - pulses[0], RD + RP * (k - 1));
`else
    check("hold_pulses", pulses.size(), 1);
`endif
    repeat (10) step(0);
    // randomized levels with bounce-length runs and occasional resets
    for (int r = 0; r < 400; r++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      repeat (len) step(lvl);
      if ($urandom_range(0, 39) == 0) apply_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
